uart_rx: RTL

//  8N1 UART receiver, companion to the SoC UART transmit path (same clock, baud, frame format).

---
 rtl/uart_rx.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ready byte output.
// Synchronises rxd, finds the start bit, samples 8 data bits LSB-first at bit centre and
// checks the stop bit. Framing errors and overruns are reported as one-cycle pulses.
// Optional build macro: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around each
// nominal sample point; the decision is then taken one clock later.
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 27_000_000,
    parameter int unsigned UART_BAUD = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BAUD;
    localparam int unsigned HALF_CNT     = BAUD_CNT_MAX / 2;

`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned SAMPLE_LAG = 1;
`else
    localparam int unsigned SAMPLE_LAG = 0;
`endif

    // Count values at which a sample decision is taken. With majority sampling the
    // decision lands one clock after the nominal point, so the counter restarts at 1
    // to keep every bit period exactly BAUD_CNT_MAX clocks long.
    localparam logic [12:0] START_DEC   = 13'(HALF_CNT - 1 + SAMPLE_LAG);
    localparam logic [12:0] BIT_DEC     = 13'(BAUD_CNT_MAX - 1 + SAMPLE_LAG);
    localparam logic [12:0] CNT_RESTART = 13'(SAMPLE_LAG);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // Input synchroniser and edge detector
    logic rxd_meta_q;
    logic rxd_sync_q;
    logic rxd_prev_q;
    logic fall_edge;

    // Receive FSM state
    state_e      state_q, state_d;
    logic [12:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        deliver_q, deliver_d;
    logic        frame_err_q, frame_err_d;

    // Output side
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;

    logic [12:0] cur_dec;
    logic        at_dec;
    logic        sample_bit;

    // Two-flop synchroniser plus one delay flop for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    assign fall_edge = rxd_prev_q & ~rxd_sync_q;

    assign cur_dec = (state_q == StStart) ? START_DEC : BIT_DEC;
    assign at_dec  = (baud_cnt_q == cur_dec);

`ifdef UART_RX_MAJORITY_EN
    logic maj_a_q;
    logic maj_b_q;

    // Capture the two samples preceding the decision point; the third is the live sync bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maj_a_q <= 1'b1;
            maj_b_q <= 1'b1;
        end else if (state_q != StIdle) begin
            if (baud_cnt_q == cur_dec - 13'd2) begin
                maj_a_q <= rxd_sync_q;
            end
            if (baud_cnt_q == cur_dec - 13'd1) begin
                maj_b_q <= rxd_sync_q;
            end
        end
    end

    assign sample_bit = (maj_a_q & maj_b_q) | (maj_a_q & rxd_sync_q) | (maj_b_q & rxd_sync_q);
`else
    assign sample_bit = rxd_sync_q;
`endif

    // FSM and datapath state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            baud_cnt_q  <= 13'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            deliver_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            deliver_q   <= deliver_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic: start qualification, data shifting and stop-bit check
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q + 13'd1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        deliver_d   = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_cnt_d = 13'd0;
                if (fall_edge) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (at_dec) begin
                    if (!sample_bit) begin
                        state_d    = StData;
                        baud_cnt_d = CNT_RESTART;
                        bit_idx_d  = 3'd0;
                    end else begin
                        // Line back high at mid start bit: treat as a glitch
                        state_d    = StIdle;
                        baud_cnt_d = 13'd0;
                    end
                end
            end
            StData: begin
                if (at_dec) begin
                    shift_d    = {sample_bit, shift_q[7:1]};
                    baud_cnt_d = CNT_RESTART;
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (at_dec) begin
                    // Returning to idle means a held-low line needs a fresh 1->0 edge
                    state_d    = StIdle;
                    baud_cnt_d = 13'd0;
                    if (sample_bit) begin
                        deliver_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                baud_cnt_d = 13'd0;
            end
        endcase
    end

    // Output registers for the byte interface
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    // Delivery and handshake: a new byte may replace one being accepted in the same cycle
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (deliver_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
